uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- UART receiver that deserializes 8N1 command bytes from the BLE module line (e.g. 'g' = 0x67, 's' = 0x73) into a parallel byte plus a ready flag.
- It is the receive end of the link driven by UART_tx in the Segway bench, and feeds the auth/command logic inside Segway.
- Adds false-start rejection, framing-error detection and overrun flagging on top of basic reception.

Parameters:
- BAUD_DIV, 2604, clk cycles per bit (50 MHz / 19200 baud); must be >= 16.

Ports:
- clk  input  1  system clock, 50 MHz
- rst  input  1  synchronous active-high reset
- RX  input  1  asynchronous serial line; idles high
- clr_rdy  input  1  one-cycle pulse from consumer; acknowledges rx_data
- rx_data  output  8  last good received byte
- rdy  output  1  level; new byte valid, held until clr_rdy or reset
- frm_err  output  1  one-cycle pulse; stop bit sampled low
- ovr  output  1  level; a byte completed while rdy was still 1; cleared by clr_rdy or reset

Behaviour:
- Reset is synchronous on the clk edge while rst=1. It forces rdy=0, rx_data=0x00, frm_err=0, ovr=0, both RX sync flops=1, state=IDLE, bit/baud counters=0.
- A reset asserted mid-frame abandons the frame; no rdy or frm_err results from it.
- RX is double-flopped before any use. rx_s is the second flop.
- States are IDLE, START, DATA, STOP and WAIT_HI.
- IDLE: a falling edge on rx_s (previous 1, current 0) moves to START and loads the baud counter with BAUD_DIV/2.
- START: when the counter expires, rx_s is sampled.
  - rx_s=1: false start; return to IDLE with no outputs changed.
  - rx_s=0: move to DATA, load the counter with BAUD_DIV, clear the bit count.
- DATA: each counter expiry samples rx_s into a shift register, LSB first (right shift, new bit at MSB), and increments the bit count.
  - After the 8th sample, move to STOP and reload BAUD_DIV.
- STOP: on expiry, sample rx_s.
  - rx_s=1: rx_data <= shift register; rdy <= 1; if rdy was already 1 and clr_rdy is not asserted that cycle, ovr <= 1. Return to IDLE.
  - rx_s=0: frm_err pulses for 1 cycle; rx_data, rdy and ovr are unchanged; go to WAIT_HI.
- WAIT_HI: stay until rx_s=1, then go to IDLE. This prevents a break or low line from being decoded as back-to-back starts.
- Latency: let cycle 0 be the first clk edge that captures raw RX=0 into sync flop 1.
  - rdy (or frm_err) is first high after the edge at cycle BAUD_DIV/2 + 9*BAUD_DIV + 3.
  - With the default, that is cycle 24741.
- Sample points are mid-bit.
  - Each bit is sampled exactly BAUD_DIV cycles after the previous sample.
  - The start bit is sampled BAUD_DIV/2 cycles after the detected edge.
- clr_rdy clears rdy and ovr on the next edge.
  - Simultaneous byte completion and clr_rdy: the new byte wins; rdy stays 1 and ovr stays/becomes 0.
  - clr_rdy while rdy=0 has no effect.
- rx_data is held stable while rdy=0 after clr_rdy. It changes only on a good stop bit.
- Back-to-back frames are accepted. A start edge arriving in IDLE one cycle after STOP completes is decoded normally.
- Counters saturate to nothing: the baud counter is ceil(log2(BAUD_DIV+1)) bits and the bit count is 4 bits, with no wrap-around reachable in legal operation.

Test Plan:
- Reset, then send 0x67 via UART_tx -> rdy rises at cycle 24741 ±0 after the start-bit capture; rx_data=0x67, frm_err never pulses, ovr=0. Then clr_rdy -> rdy=0 next cycle, rx_data still 0x67.
- Send 0x73 then 0x67 back-to-back without clr_rdy -> after 2nd frame rx_data=0x67, rdy=1, ovr=1. Then clr_rdy -> rdy=0, ovr=0.
- Drive RX low for 500 cycles then high (glitch shorter than BAUD_DIV/2) -> returns to IDLE; rdy, frm_err and rx_data unchanged. A following 0x55 frame is received correctly.
- Send frame 0xA5 with the stop bit forced low, RX then held low 3*BAUD_DIV -> single frm_err pulse, rdy=0, rx_data keeps its prior value, no further frames decoded until RX high. Then 0x3C -> rdy=1, rx_data=0x3C.
- Assert rst during bit 4 of 0x67 -> all outputs zero next edge. With no start edge, nothing is reported; the next 0x73 is received as 0x73.
- Pulse clr_rdy on the exact cycle the STOP sample of 0x61 succeeds while rdy=1 -> rdy=1, rx_data=0x61, ovr=0.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 UART receiver: double-synchronised RX, mid-bit sampling, false-start rejection,
// framing-error pulse and overrun flag. Every output is driven directly by a flop.
module uart_rx #(
   parameter int BAUD_DIV = 2604
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       RX,
   input  logic       clr_rdy,
   output logic [7:0] rx_data,
   output logic       rdy,
   output logic       frm_err,
   output logic       ovr
);

   localparam int CW = $clog2(BAUD_DIV + 1);
   // Expiry fires on the zero count, so a full-bit reload is one short of BAUD_DIV.
   localparam logic [CW-1:0] HALF_LD = CW'(BAUD_DIV / 2);
   localparam logic [CW-1:0] FULL_LD = CW'(BAUD_DIV - 1);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      START   = 3'd1,
      DATA    = 3'd2,
      STOP    = 3'd3,
      WAIT_HI = 3'd4
   } state_t;

   state_t        state_q, state_d;
   logic          rx_sync1_q, rx_sync2_q, rx_prev_q;
   logic [CW-1:0] baud_cnt_q, baud_cnt_d;
   logic [3:0]    bit_cnt_q, bit_cnt_d;
   logic [7:0]    shift_q, shift_d;
   logic [7:0]    rx_data_q, rx_data_d;
   logic          rdy_q, rdy_d;
   logic          frm_err_q, frm_err_d;
   logic          ovr_q, ovr_d;
   logic          rx_s;
   logic          baud_exp_s;

   assign rx_s       = rx_sync2_q;
   assign baud_exp_s = (baud_cnt_q == {CW{1'b0}});

   // Next-state, counter and output-register computation.
   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      rx_data_d  = rx_data_q;
      frm_err_d  = 1'b0;

      if (!baud_exp_s) begin
         baud_cnt_d = baud_cnt_q - CW'(1);
      end else begin
         baud_cnt_d = baud_cnt_q;
      end

      if (clr_rdy) begin
         rdy_d = 1'b0;
         ovr_d = 1'b0;
      end else begin
         rdy_d = rdy_q;
         ovr_d = ovr_q;
      end

      case (state_q)
         IDLE: begin
            if (rx_prev_q && !rx_s) begin
               state_d    = START;
               baud_cnt_d = HALF_LD;
            end else begin
               state_d = IDLE;
            end
         end
         START: begin
            if (baud_exp_s && rx_s) begin
               state_d = IDLE;
            end else if (baud_exp_s) begin
               state_d    = DATA;
               baud_cnt_d = FULL_LD;
               bit_cnt_d  = 4'd0;
            end else begin
               state_d = START;
            end
         end
         DATA: begin
            if (baud_exp_s) begin
               shift_d    = {rx_s, shift_q[7:1]};
               bit_cnt_d  = bit_cnt_q + 4'd1;
               baud_cnt_d = FULL_LD;
               if (bit_cnt_q == 4'd7) begin
                  state_d = STOP;
               end else begin
                  state_d = DATA;
               end
            end else begin
               state_d = DATA;
            end
         end
         STOP: begin
            if (baud_exp_s && rx_s) begin
               // A completing byte beats a simultaneous clr_rdy; overrun only if nobody acked.
               rx_data_d = shift_q;
               rdy_d     = 1'b1;
               if (rdy_q && !clr_rdy) begin
                  ovr_d = 1'b1;
               end else begin
                  ovr_d = 1'b0;
               end
               state_d = IDLE;
            end else if (baud_exp_s) begin
               frm_err_d = 1'b1;
               state_d   = WAIT_HI;
            end else begin
               state_d = STOP;
            end
         end
         WAIT_HI: begin
            if (rx_s) begin
               state_d = IDLE;
            end else begin
               state_d = WAIT_HI;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, synchroniser and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         rx_sync1_q <= 1'b1;
         rx_sync2_q <= 1'b1;
         rx_prev_q  <= 1'b1;
         baud_cnt_q <= {CW{1'b0}};
         bit_cnt_q  <= 4'd0;
         shift_q    <= 8'h00;
         rx_data_q  <= 8'h00;
         rdy_q      <= 1'b0;
         frm_err_q  <= 1'b0;
         ovr_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         rx_sync1_q <= RX;
         rx_sync2_q <= rx_sync1_q;
         rx_prev_q  <= rx_sync2_q;
         baud_cnt_q <= baud_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         rx_data_q  <= rx_data_d;
         rdy_q      <= rdy_d;
         frm_err_q  <= frm_err_d;
         ovr_q      <= ovr_d;
      end
   end

   assign rx_data = rx_data_q;
   assign rdy     = rdy_q;
   assign frm_err = frm_err_q;
   assign ovr     = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at a short baud divider; each task drives one scenario
// and compares outputs against hand-computed values.
module tb_uart_rx;

   localparam int B = 32;

   logic       clk;
   logic       rst;
   logic       RX;
   logic       clr_rdy;
   logic [7:0] rx_data;
   logic       rdy;
   logic       frm_err;
   logic       ovr;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int start_cyc = 0;
   int rise_cnt = 0;
   int rise_cyc = 0;
   int frm_cnt  = 0;
   logic rdy_prev = 1'b0;

   uart_rx #(.BAUD_DIV(B)) dut (
      .clk     (clk),
      .rst     (rst),
      .RX      (RX),
      .clr_rdy (clr_rdy),
      .rx_data (rx_data),
      .rdy     (rdy),
      .frm_err (frm_err),
      .ovr     (ovr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Records rdy rising edges and frm_err high cycles, sampled on the falling edge.
   always @(negedge clk) begin
      rdy_prev <= rdy;
      if (rdy === 1'b1 && rdy_prev === 1'b0) begin
         rise_cnt <= rise_cnt + 1;
         rise_cyc <= cyc;
      end
      if (frm_err === 1'b1) frm_cnt <= frm_cnt + 1;
   end

   // Must be called at a falling edge; returns at the falling edge ending the stop bit.
   task automatic send_frame(input logic [7:0] b, input logic stop_bit);
      RX = 1'b0;
      start_cyc = cyc;
      repeat (B) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         RX = b[i];
         repeat (B) @(negedge clk);
      end
      RX = stop_bit;
      repeat (B) @(negedge clk);
      RX = 1'b1;
   endtask

   task automatic pulse_clr();
      clr_rdy = 1'b1;
      @(negedge clk);
      clr_rdy = 1'b0;
   endtask

   task automatic test_reset();
      RX = 1'b1; clr_rdy = 1'b0; rst = 1'b1;
      repeat (3) @(negedge clk);
      n_checks++; if (rdy !== 1'b0) begin n_fail++; $display("FAIL reset_rdy: got %b expected 0", rdy); end
      n_checks++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_rx_data: got %h expected 00", rx_data); end
      n_checks++; if (frm_err !== 1'b0) begin n_fail++; $display("FAIL reset_frm_err: got %b expected 0", frm_err); end
      n_checks++; if (ovr !== 1'b0) begin n_fail++; $display("FAIL reset_ovr: got %b expected 0", ovr); end
      rst = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_basic();
      int r0, f0, lat;
      r0 = rise_cnt; f0 = frm_cnt;
      send_frame(8'h67, 1'b1);
      // cycle 0 is the posedge after start_cyc was read: B/2 + 9*B + 3 = 16 + 288 + 3
      lat = rise_cyc - start_cyc - 1;
      n_checks++; if (lat !== 307) begin n_fail++; $display("FAIL basic_latency: got %0d expected 307", lat); end
      n_checks++; if (rise_cnt - r0 !== 1) begin n_fail++; $display("FAIL basic_rise_count: got %0d expected 1", rise_cnt - r0); end
      n_checks++; if (rdy !== 1'b1) begin n_fail++; $display("FAIL basic_rdy: got %b expected 1", rdy); end
      n_checks++; if (rx_data !== 8'h67) begin n_fail++; $display("FAIL basic_rx_data: got %h expected 67", rx_data); end
      n_checks++; if (ovr !== 1'b0) begin n_fail++; $display("FAIL basic_ovr: got %b expected 0", ovr); end
      n_checks++; if (frm_cnt - f0 !== 0) begin n_fail++; $display("FAIL basic_frm_err: got %0d pulses expected 0", frm_cnt - f0); end
      pulse_clr();
      n_checks++; if (rdy !== 1'b0) begin n_fail++; $display("FAIL basic_clr_rdy: got %b expected 0", rdy); end
      n_checks++; if (rx_data !== 8'h67) begin n_fail++; $display("FAIL basic_clr_data: got %h expected 67", rx_data); end
   endtask

   task automatic test_back_to_back();
      send_frame(8'h73, 1'b1);
      n_checks++; if (ovr !== 1'b0) begin n_fail++; $display("FAIL b2b_first_ovr: got %b expected 0", ovr); end
      send_frame(8'h67, 1'b1);
      n_checks++; if (rx_data !== 8'h67) begin n_fail++; $display("FAIL b2b_rx_data: got %h expected 67", rx_data); end
      n_checks++; if (rdy !== 1'b1) begin n_fail++; $display("FAIL b2b_rdy: got %b expected 1", rdy); end
      n_checks++; if (ovr !== 1'b1) begin n_fail++; $display("FAIL b2b_ovr: got %b expected 1", ovr); end
      pulse_clr();
      n_checks++; if (rdy !== 1'b0) begin n_fail++; $display("FAIL b2b_clr_rdy: got %b expected 0", rdy); end
      n_checks++; if (ovr !== 1'b0) begin n_fail++; $display("FAIL b2b_clr_ovr: got %b expected 0", ovr); end
   endtask

   task automatic test_false_start();
      int r0, f0;
      r0 = rise_cnt; f0 = frm_cnt;
      RX = 1'b0;
      repeat (B/2 - 4) @(negedge clk);
      RX = 1'b1;
      repeat (3*B) @(negedge clk);
      n_checks++; if (rdy !== 1'b0) begin n_fail++; $display("FAIL glitch_rdy: got %b expected 0", rdy); end
      n_checks++; if (rx_data !== 8'h67) begin n_fail++; $display("FAIL glitch_rx_data: got %h expected 67", rx_data); end
      n_checks++; if (frm_cnt - f0 !== 0) begin n_fail++; $display("FAIL glitch_frm_err: got %0d pulses expected 0", frm_cnt - f0); end
      n_checks++; if (rise_cnt - r0 !== 0) begin n_fail++; $display("FAIL glitch_rise: got %0d expected 0", rise_cnt - r0); end
      send_frame(8'h55, 1'b1);
      n_checks++; if (rx_data !== 8'h55) begin n_fail++; $display("FAIL glitch_next_data: got %h expected 55", rx_data); end
      n_checks++; if (rdy !== 1'b1) begin n_fail++; $display("FAIL glitch_next_rdy: got %b expected 1", rdy); end
      pulse_clr();
   endtask

   task automatic test_framing();
      int r0, f0;
      r0 = rise_cnt; f0 = frm_cnt;
      send_frame(8'hA5, 1'b0);
      RX = 1'b0;
      repeat (3*B) @(negedge clk);
      n_checks++; if (frm_cnt - f0 !== 1) begin n_fail++; $display("FAIL frm_pulse_count: got %0d expected 1", frm_cnt - f0); end
      n_checks++; if (rdy !== 1'b0) begin n_fail++; $display("FAIL frm_rdy: got %b expected 0", rdy); end
      n_checks++; if (rx_data !== 8'h55) begin n_fail++; $display("FAIL frm_rx_data: got %h expected 55", rx_data); end
      RX = 1'b1;
      repeat (2*B) @(negedge clk);
      n_checks++; if (rise_cnt - r0 !== 0) begin n_fail++; $display("FAIL frm_no_decode: got %0d expected 0", rise_cnt - r0); end
      send_frame(8'h3C, 1'b1);
      n_checks++; if (rx_data !== 8'h3C) begin n_fail++; $display("FAIL frm_next_data: got %h expected 3c", rx_data); end
      n_checks++; if (rdy !== 1'b1) begin n_fail++; $display("FAIL frm_next_rdy: got %b expected 1", rdy); end
      pulse_clr();
   endtask

   task automatic test_reset_midframe();
      logic [7:0] b;
      int r0, f0;
      b = 8'h67;
      RX = 1'b0;
      repeat (B) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         RX = b[i];
         repeat (B) @(negedge clk);
      end
      RX = b[4];
      repeat (B/2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      RX = 1'b1;
      r0 = rise_cnt; f0 = frm_cnt;
      n_checks++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL rst_mid_rx_data: got %h expected 00", rx_data); end
      n_checks++; if (rdy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_rdy: got %b expected 0", rdy); end
      n_checks++; if (ovr !== 1'b0) begin n_fail++; $display("FAIL rst_mid_ovr: got %b expected 0", ovr); end
      repeat (12*B) @(negedge clk);
      n_checks++; if (rise_cnt - r0 !== 0) begin n_fail++; $display("FAIL rst_mid_no_rdy: got %0d expected 0", rise_cnt - r0); end
      n_checks++; if (frm_cnt - f0 !== 0) begin n_fail++; $display("FAIL rst_mid_no_frm: got %0d expected 0", frm_cnt - f0); end
      send_frame(8'h73, 1'b1);
      n_checks++; if (rx_data !== 8'h73) begin n_fail++; $display("FAIL rst_mid_next_data: got %h expected 73", rx_data); end
      n_checks++; if (rdy !== 1'b1) begin n_fail++; $display("FAIL rst_mid_next_rdy: got %b expected 1", rdy); end
      n_checks++; if (ovr !== 1'b0) begin n_fail++; $display("FAIL rst_mid_next_ovr: got %b expected 0", ovr); end
   endtask

   // Entered with rdy=1; clr_rdy lands on the posedge that samples the good stop bit.
   task automatic test_clr_collision();
      int r0;
      r0 = rise_cnt;
      fork
         send_frame(8'h61, 1'b1);
         begin
            repeat (307) @(negedge clk);
            clr_rdy = 1'b1;
            @(negedge clk);
            clr_rdy = 1'b0;
         end
      join
      n_checks++; if (rdy !== 1'b1) begin n_fail++; $display("FAIL coll_rdy: got %b expected 1", rdy); end
      n_checks++; if (rx_data !== 8'h61) begin n_fail++; $display("FAIL coll_rx_data: got %h expected 61", rx_data); end
      n_checks++; if (ovr !== 1'b0) begin n_fail++; $display("FAIL coll_ovr: got %b expected 0", ovr); end
      n_checks++; if (rise_cnt - r0 !== 0) begin n_fail++; $display("FAIL coll_rdy_dropped: got %0d rises expected 0", rise_cnt - r0); end
   endtask

   initial begin
      rst = 1'b1; RX = 1'b1; clr_rdy = 1'b0;
      @(negedge clk);
      test_reset();
      test_basic();
      test_back_to_back();
      test_false_start();
      test_framing();
      test_reset_midframe();
      test_clr_collision();
      repeat (4) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
